// File: rtl/uart_debug_sched.sv
// Round-robin byte scheduler in front of a UART transmitter: strobes are paced one
// character slot apart and a requester keeps ownership until it sends a last byte.
module uart_debug_sched #(
  parameter int NUM_REQ      = 4,
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int IW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_valid,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 lock_timeout
);

  localparam int CLK_DIV     = CLK_FREQ / BAUD_RATE;
  localparam int SLOT_CYCLES = 11 * (CLK_DIV + 1);
  localparam int PW          = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int TW          = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic [PW-1:0]        pace_cnt_r;
  logic [TW-1:0]        tmo_cnt_r;
  logic [IW-1:0]        rr_ptr_r, grant_id_r, win_s, sel_s, next_ptr_s;
  logic [7:0]           uart_data_r, sel_data_s;
  logic                 uart_valid_r, lock_timeout_r, last_r, sel_last_s;
  logic                 found_s, accept_s, tmo_hit_s;
  logic [NUM_REQ-1:0]   ready_s;
  int                   dist_s, best_d_s;

  assign sel_s      = (state_r == HOLD) ? grant_id_r : win_s;
  assign accept_s   = |(req_valid & ready_s);
  assign tmo_hit_s  = (tmo_cnt_r == TW'(LOCK_TIMEOUT - 1));
  assign next_ptr_s = (grant_id_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : grant_id_r + IW'(1);

  // Round-robin winner: valid requester at the smallest distance above rr_ptr.
  always_comb begin
    found_s  = 1'b0;
    win_s    = {IW{1'b0}};
    best_d_s = NUM_REQ;
    dist_s   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = i - int'(rr_ptr_r);
      if (dist_s < 0) begin
        dist_s = dist_s + NUM_REQ;
      end else begin
        dist_s = dist_s;
      end
      if (req_valid[i] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        win_s    = IW'(i);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an accept in HOLD wins over an expiring timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = PACE;
        else          state_next_s = IDLE;
      end
      PACE: begin
        if (pace_cnt_r != {PW{1'b0}}) state_next_s = PACE;
        else if (last_r)              state_next_s = IDLE;
        else                          state_next_s = HOLD;
      end
      HOLD: begin
        if (accept_s)       state_next_s = PACE;
        else if (tmo_hit_s) state_next_s = IDLE;
        else                state_next_s = HOLD;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Ready generation and selection of the byte/last flag of the eligible requester.
  always_comb begin
    ready_s    = {NUM_REQ{1'b0}};
    sel_data_s = 8'h00;
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == sel_s) begin
        sel_data_s = req_data[8*i +: 8];
        sel_last_s = req_last[i];
      end else begin
        sel_last_s = sel_last_s;
      end
      if (rst) begin
        ready_s[i] = 1'b0;
      end else if ((state_r == IDLE) && found_s && (win_s == IW'(i))) begin
        ready_s[i] = 1'b1;
      end else if ((state_r == HOLD) && (grant_id_r == IW'(i))) begin
        ready_s[i] = req_valid[i];
      end else begin
        ready_s[i] = 1'b0;
      end
    end
  end

  // Datapath: captured byte, strobe, owner, pointer and the two counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_data_r    <= 8'h00;
      uart_valid_r   <= 1'b0;
      lock_timeout_r <= 1'b0;
      last_r         <= 1'b0;
      grant_id_r     <= {IW{1'b0}};
      rr_ptr_r       <= {IW{1'b0}};
      pace_cnt_r     <= {PW{1'b0}};
      tmo_cnt_r      <= {TW{1'b0}};
    end else begin
      uart_valid_r   <= accept_s;
      lock_timeout_r <= 1'b0;
      if (accept_s) begin
        uart_data_r <= sel_data_s;
        last_r      <= sel_last_s;
        grant_id_r  <= sel_s;
        pace_cnt_r  <= PW'(SLOT_CYCLES - 1);
        tmo_cnt_r   <= {TW{1'b0}};
      end else begin
        case (state_r)
          PACE: begin
            if (pace_cnt_r != {PW{1'b0}}) pace_cnt_r <= pace_cnt_r - PW'(1);
            else if (last_r)              rr_ptr_r   <= next_ptr_s;
            else                          tmo_cnt_r  <= {TW{1'b0}};
          end
          HOLD: begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            if (tmo_hit_s) begin
              rr_ptr_r       <= next_ptr_s;
              lock_timeout_r <= 1'b1;
            end
          end
          default: begin
            tmo_cnt_r <= tmo_cnt_r;
          end
        endcase
      end
    end
  end

  assign req_ready    = ready_s;
  assign uart_data    = uart_data_r;
  assign uart_valid   = uart_valid_r;
  assign grant_id     = grant_id_r;
  assign busy         = (state_r != IDLE);
  assign lock_timeout = lock_timeout_r;

endmodule

// File: tb/tb_uart_debug_sched.sv
// Scoreboard bench for uart_debug_sched: a message-level scheduling model predicts
// every UART strobe and lock timeout; a monitor compares them as they appear.
module tb_uart_debug_sched;

  localparam int N     = 4;
  localparam int CLK_F = 1000;
  localparam int BAUD  = 100;
  localparam int LT    = 50;
  localparam int SLOT  = 11 * (CLK_F / BAUD + 1);
  localparam int GAP   = SLOT + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [7:0]     uart_data;
  logic           uart_valid, busy, lock_timeout;
  logic [1:0]     grant_id;

  uart_debug_sched #(
    .NUM_REQ(N), .CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
    .uart_valid(uart_valid), .grant_id(grant_id), .busy(busy),
    .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         id;
    int         c;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  int         tmo_q[$];
  logic [8:0] strm[N][$];   // per requester: {last, data} still to be offered
  int         ptr_m = 0;    // model round-robin pointer
  exp_t       mon_x;
  int         mon_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (strm[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive_heads();
    for (int i = 0; i < N; i++) begin
      if (strm[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = strm[i][0][7:0];
        req_last[i]        = strm[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // Offer every queued stream with valid held steadily; the model predicts the
  // whole schedule up front: owner keeps the link while it has bytes, releases
  // on a last byte, and times out LT cycles into HOLD when it runs dry.
  task automatic run_scenario();
    logic [8:0]   m[N][$];
    logic [8:0]   e;
    logic [N-1:0] acc;
    int           tt, g, budget;
    @(posedge clk); #1;
    tt = cyc;
    for (int i = 0; i < N; i++) m[i] = strm[i];
    forever begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && m[(ptr_m + k) % N].size() > 0) g = (ptr_m + k) % N;
      if (g < 0) break;
      forever begin
        e = m[g].pop_front();
        exp_q.push_back('{e[7:0], g, tt + 1});
        if (e[8]) begin
          ptr_m = (g + 1) % N;
          tt += GAP;
          break;
        end else if (m[g].size() == 0) begin
          tmo_q.push_back(tt + GAP + LT);
          ptr_m = (g + 1) % N;
          tt += GAP + LT;
          break;
        end else begin
          tt += GAP;
        end
      end
    end
    drive_heads();
    budget = 0;
    while ((pending() || busy) && budget < 20000) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (acc[i]) void'(strm[i].pop_front());
      drive_heads();
      budget++;
    end
    chk("scenario_budget_expired", 32'(budget >= 20000), 32'd0);
    repeat (2) @(negedge clk);
    chk("expected_strobes_left", 32'(exp_q.size()), 32'd0);
    chk("expected_timeouts_left", 32'(tmo_q.size()), 32'd0);
  endtask

  // Monitor: compare each strobe and timeout pulse with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          mon_x = exp_q.pop_front();
          chk("uart_data", 32'(uart_data), 32'(mon_x.d));
          chk("grant_id", 32'(grant_id), 32'(mon_x.id));
          chk("strobe_cycle", 32'(cyc), 32'(mon_x.c));
        end
      end
      if (lock_timeout === 1'b1) begin
        if (tmo_q.size() == 0) begin
          chk("unexpected_timeout", 32'd1, 32'd0);
        end else begin
          mon_t = tmo_q.pop_front();
          chk("timeout_cycle", 32'(cyc), 32'(mon_t));
        end
      end
      if (req_ready !== {N{1'b0}})
        chk("ready_onehot_and_valid",
            32'(($countones(req_ready) == 1) && ((req_ready & ~req_valid) == {N{1'b0}})), 32'd1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2, n;
    rst       = 1'b1;
    req_valid = {N{1'b1}};
    req_data  = 32'h0;
    req_last  = {N{1'b0}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_uart_valid", 32'(uart_valid), 32'd0);
    chk("rst_uart_data", 32'(uart_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = {N{1'b0}};

    // Round robin 0,1,2,3 then req0 again.
    strm[0] = '{9'h110, 9'h154};
    strm[1] = '{9'h121};
    strm[2] = '{9'h132};
    strm[3] = '{9'h143};
    run_scenario();

    // req1 single byte moves the pointer to 2; req2's message then locks out req1.
    strm[1] = '{9'h1E1, 9'h1E2};
    strm[2] = '{9'h001, 9'h002, 9'h103};
    run_scenario();

    // req3 stalls mid-message, times out, pointer wraps past 3 to find req1.
    strm[3] = '{9'h055};
    strm[1] = '{9'h166};
    run_scenario();

    // Single byte: ready same cycle, busy through T+121, idle at T+122.
    @(posedge clk); #1;
    t = cyc;
    req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
    exp_q.push_back('{8'hA5, 0, t + 1});
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    while (cyc < t + SLOT) @(negedge clk);
    chk("single_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_idle", 32'(busy), 32'd0);
    ptr_m = 1;

    // Randomised streams.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++)
          strm[i].push_back({($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 8'($urandom)});
      end
      run_scenario();
    end

    // Reset 30 cycles into PACE aborts the slot; req1 is taken right after.
    @(posedge clk); #1;
    t = cyc;
    req_valid = 4'b0001; req_data[7:0] = 8'hAA; req_last = 4'b0001;
    exp_q.push_back('{8'hAA, 0, t + 1});
    @(posedge clk); #1;
    req_valid = 4'b0010; req_data[15:8] = 8'h9C; req_last = 4'b0010;
    while (cyc < t + 30) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midpace_rst_ready", 32'(req_ready), 32'd0);
    chk("midpace_rst_busy", 32'(busy), 32'd0);
    chk("midpace_rst_data", 32'(uart_data), 32'd0);
    chk("midpace_rst_grant", 32'(grant_id), 32'd0);
    chk("midpace_rst_valid", 32'(uart_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    t2 = cyc;
    exp_q.push_back('{8'h9C, 1, t2 + 1});
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (GAP + 4) @(posedge clk);
    ptr_m = 2;
    @(negedge clk);
    chk("final_strobes_left", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_debug_sched.md
UART_DEBUG_SCHED -- requirements
Module: uart_debug_sched

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 4: number of requesters, 2..8.
- CLK_FREQ, default 100000000: clock frequency in Hz.
- BAUD_RATE, default 115200: UART bit rate.
- LOCK_TIMEOUT, default 65535: idle cycles allowed before a held lock is released.
REQ-002 Derived constants SHALL be CLK_DIV = CLK_FREQ/BAUD_RATE (integer division) and SLOT_CYCLES = 11*(CLK_DIV+1); IW = max(1, clog2(NUM_REQ)).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- req_data, input, 8*NUM_REQ: byte of requester i in bits [8i+7:8i].
- req_valid, input, NUM_REQ: requester i offers a byte.
- req_last, input, NUM_REQ: the offered byte ends requester i's message.
- req_ready, output, NUM_REQ: byte of requester i is accepted this cycle.
- uart_data, output, 8: byte to the UART transmitter.
- uart_valid, output, 1: single-cycle start strobe to the UART transmitter.
- grant_id, output, IW: index of the current or last owner.
- busy, output, 1: high in any state other than IDLE.
- lock_timeout, output, 1: one-cycle pulse when a lock is force-released.

Function
REQ-005 The FSM SHALL have exactly three states:
- IDLE: no owner.
- PACE: a byte is being serialised.
- HOLD: an owner is locked and no byte is in flight.
REQ-006 Accept condition: req_valid[i] && req_ready[i]; at most one req_ready bit SHALL be high in any cycle.
REQ-007 IDLE arbitration SHALL be round-robin.
- Search starts at rr_ptr and proceeds upward modulo NUM_REQ.
- The first requester with req_valid set is the winner g.
- req_ready[g] SHALL be asserted combinationally in that same cycle.
REQ-008 HOLD: only the owner SHALL be eligible; req_ready[owner] = req_valid[owner]; all other ready bits SHALL be 0.
REQ-009 PACE: req_ready SHALL be all zeros.
REQ-010 On accept in cycle T, the block SHALL:
- register uart_data = the accepted byte;
- drive uart_valid = 1 in cycle T+1 only;
- set grant_id = g;
- load the pace counter with SLOT_CYCLES-1 and enter PACE.
REQ-011 PACE SHALL decrement the counter each cycle. When the counter reaches 0:
- If the accepted byte had req_last = 1, go to IDLE and set rr_ptr = (owner+1) mod NUM_REQ.
- Otherwise, go to HOLD and clear the timeout counter.
REQ-012 Consequence of REQ-010/011: successive accepts SHALL be spaced at least SLOT_CYCLES+1 cycles apart, so uart_valid never strikes while the UART transmitter is shifting.
REQ-013 The HOLD timeout counter SHALL increment on every cycle without an accept.
- On reaching LOCK_TIMEOUT, go to IDLE, set rr_ptr = owner+1, and pulse lock_timeout for one cycle.
- An accept in that same cycle SHALL take precedence over the timeout: no timeout pulse, normal REQ-010 behaviour.
REQ-014 Simultaneous requests in IDLE SHALL be resolved solely by rr_ptr. Requests from non-owners during PACE or HOLD SHALL be ignored, with no loss of their data (they are not acknowledged).
REQ-015 rr_ptr wrap-around: NUM_REQ-1 + 1 SHALL wrap to 0.
REQ-016 The pace and timeout counters SHALL be sized to hold SLOT_CYCLES-1 and LOCK_TIMEOUT without overflow.
REQ-017 req_data and req_last SHALL be sampled only on accept.
REQ-018 Changes in req_valid without an accept SHALL have no effect on state, other than resetting the timeout counter on accept.

Reset
REQ-019 With rst high at a clock edge, the block SHALL clear all of the following next cycle:
- state = IDLE;
- uart_valid = 0, uart_data = 0x00;
- grant_id = 0, rr_ptr = 0;
- pace and timeout counters = 0;
- lock_timeout = 0.
REQ-020 req_ready SHALL be all zeros while rst is high.
REQ-021 Reset asserted mid-PACE or mid-HOLD SHALL abort immediately with no further uart_valid strobe.

Verification
Benches use CLK_FREQ=1000, BAUD_RATE=100, NUM_REQ=4, LOCK_TIMEOUT=50, giving CLK_DIV=10 and SLOT_CYCLES=121.
REQ-022 Single byte: req0 offers 0xA5 with last=1 at cycle T -> req_ready[0]=1 at T; uart_valid=1 with uart_data=0xA5 at T+1 only; busy through T+121; IDLE at T+122.
REQ-023 Round-robin: all four requesters hold single bytes 0x10/0x21/0x32/0x43 with last=1 -> grant order 0,1,2,3; accepts exactly 122 cycles apart; then req0 is served again.
REQ-024 Message lock: req2 sends 0x01, 0x02, 0x03 (last on 0x03) while req1 is continuously valid -> all three bytes go to the UART before any req1 byte; rr_ptr=3 afterwards.
REQ-025 Timeout: req3 sends 0x55 with last=0, then drops valid -> lock_timeout pulses exactly 50 cycles after entering HOLD; next grant goes to the lowest valid index starting at 0 (wrap).
REQ-026 Reset mid-PACE: rst asserted 30 cycles after an accept -> uart_valid stays 0; all outputs at reset values; a fresh req1 byte is accepted the first cycle after rst deasserts.
